// File: rtl/evm_booth_scheduler.sv
// Round-robin scheduler that lets several ballot booths share one evm counting core,
// sequencing candidate_ready / vote / session_done strobes and enforcing one vote per booth.
module evm_booth_scheduler #(
  parameter int NUM_BOOTHS = 4,
  parameter int CW         = 7,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_BOOTHS-1:0]   booth_req,
  input  logic [2*NUM_BOOTHS-1:0] booth_choice,
  input  logic                    close_session,
  input  logic                    evm_voting_in_progress,
  output logic                    evm_candidate_ready,
  output logic [2:0]              evm_vote,
  output logic                    evm_session_done,
  output logic [NUM_BOOTHS-1:0]   booth_ack,
  output logic [NUM_BOOTHS-1:0]   booth_nack,
  output logic                    busy,
  output logic [CW-1:0]           votes_cast,
  output logic                    session_closed,
  output logic [2:0]              dbg_state
);

  localparam int PW = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT    = 3'd1,
    S_WAIT_VIP = 3'd2,
    S_VOTE     = 3'd3,
    S_SETTLE   = 3'd4,
    S_RESP     = 3'd5,
    S_CLOSE    = 3'd6,
    S_CLOSED   = 3'd7
  } state_t;

  state_t                state, state_n;
  logic [PW-1:0]         gnt, gnt_n, rr_ptr, rr_ptr_n, win;
  logic [1:0]            choice, choice_n, win_choice;
  logic [NUM_BOOTHS-1:0] voted_mask, voted_mask_n;
  logic [CW-1:0]         votes_n;
  logic [TW-1:0]         tmo, tmo_n;
  logic                  found;

  logic                  cr_n, done_n;
  logic [2:0]            vote_n;
  logic [NUM_BOOTHS-1:0] ack_n, nack_n;

  // First requester strictly after rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_BOOTHS; k++) begin
      if (!found && booth_req[(int'(rr_ptr) + k) % NUM_BOOTHS]) begin
        found = 1'b1;
        win   = PW'((int'(rr_ptr) + k) % NUM_BOOTHS);
      end
    end
    win_choice = booth_choice[2*int'(win) +: 2];
  end

  // Outputs are computed for the state being entered and registered alongside it.
  always_comb begin
    state_n      = state;
    gnt_n        = gnt;
    choice_n     = choice;
    rr_ptr_n     = rr_ptr;
    voted_mask_n = voted_mask;
    votes_n      = votes_cast;
    tmo_n        = tmo;
    cr_n         = 1'b0;
    vote_n       = 3'b000;
    done_n       = 1'b0;
    ack_n        = '0;
    nack_n       = '0;
    case (state)
      S_IDLE: begin
        if (close_session || (&voted_mask)) begin
          state_n = S_CLOSE;
          done_n  = 1'b1;
        end else if (found) begin
          gnt_n    = win;
          choice_n = win_choice;
          rr_ptr_n = win;
          if (voted_mask[win] || (win_choice == 2'b00)) begin
            state_n     = S_RESP;
            nack_n[win] = 1'b1;
          end else begin
            state_n = S_GRANT;
            cr_n    = 1'b1;
          end
        end
      end
      S_GRANT: begin
        state_n = S_WAIT_VIP;
        tmo_n   = '0;
      end
      S_WAIT_VIP: begin
        if (evm_voting_in_progress) begin
          state_n = S_VOTE;
          case (choice)
            2'b01:   vote_n = 3'b001;
            2'b10:   vote_n = 3'b010;
            2'b11:   vote_n = 3'b100;
            default: vote_n = 3'b000;
          endcase
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          state_n     = S_RESP;
          nack_n[gnt] = 1'b1;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
      S_VOTE: state_n = S_SETTLE;
      S_SETTLE: begin
        state_n           = S_RESP;
        voted_mask_n[gnt] = 1'b1;
        ack_n[gnt]        = 1'b1;
        if (votes_cast != '1) votes_n = votes_cast + 1'b1;
      end
      S_RESP:  state_n = S_IDLE;
      S_CLOSE: state_n = S_CLOSED;
      S_CLOSED: begin
        // Skip the cycle right after a nack so a booth still dropping req is not hit twice.
        if (found && !(|booth_nack)) begin
          nack_n[win] = 1'b1;
          rr_ptr_n    = win;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= S_IDLE;
      gnt                 <= '0;
      choice              <= 2'b00;
      rr_ptr              <= PW'(NUM_BOOTHS - 1);
      voted_mask          <= '0;
      votes_cast          <= '0;
      tmo                 <= '0;
      evm_candidate_ready <= 1'b0;
      evm_vote            <= 3'b000;
      evm_session_done    <= 1'b0;
      booth_ack           <= '0;
      booth_nack          <= '0;
      busy                <= 1'b0;
      session_closed      <= 1'b0;
    end else if (!enable) begin
      state               <= S_IDLE;
      gnt                 <= '0;
      choice              <= 2'b00;
      rr_ptr              <= PW'(NUM_BOOTHS - 1);
      voted_mask          <= '0;
      votes_cast          <= '0;
      tmo                 <= '0;
      evm_candidate_ready <= 1'b0;
      evm_vote            <= 3'b000;
      evm_session_done    <= 1'b0;
      booth_ack           <= '0;
      booth_nack          <= '0;
      busy                <= 1'b0;
      session_closed      <= 1'b0;
    end else begin
      state               <= state_n;
      gnt                 <= gnt_n;
      choice              <= choice_n;
      rr_ptr              <= rr_ptr_n;
      voted_mask          <= voted_mask_n;
      votes_cast          <= votes_n;
      tmo                 <= tmo_n;
      evm_candidate_ready <= cr_n;
      evm_vote            <= vote_n;
      evm_session_done    <= done_n;
      booth_ack           <= ack_n;
      booth_nack          <= nack_n;
      busy                <= (state_n != S_IDLE) && (state_n != S_CLOSED);
      session_closed      <= (state_n == S_CLOSED);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_evm_booth_scheduler.sv
// Directed bench for evm_booth_scheduler with a small evm model answering candidate_ready.
module tb_evm_booth_scheduler;

  localparam int NB = 4;
  localparam int CW = 7;

  logic          clk, rst, enable, close_session, vip, vip_en;
  logic [NB-1:0] booth_req;
  logic [2*NB-1:0] booth_choice;
  logic          evm_candidate_ready, evm_session_done, busy, session_closed;
  logic [2:0]    evm_vote, dbg_state;
  logic [NB-1:0] booth_ack, booth_nack;
  logic [CW-1:0] votes_cast;
  logic [21:0]   all_out;

  int checks = 0;
  int passed = 0;

  evm_booth_scheduler #(.NUM_BOOTHS(NB), .CW(CW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .booth_req(booth_req), .booth_choice(booth_choice),
    .close_session(close_session), .evm_voting_in_progress(vip),
    .evm_candidate_ready(evm_candidate_ready), .evm_vote(evm_vote), .evm_session_done(evm_session_done),
    .booth_ack(booth_ack), .booth_nack(booth_nack), .busy(busy), .votes_cast(votes_cast),
    .session_closed(session_closed), .dbg_state(dbg_state)
  );

  assign all_out = {evm_candidate_ready, evm_vote, evm_session_done, booth_ack, booth_nack,
                    busy, votes_cast, session_closed};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // evm model: voting_in_progress rises the cycle after candidate_ready, falls after a vote.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vip <= 1'b0;
    else if (!vip_en) vip <= 1'b0;
    else if (evm_candidate_ready) vip <= 1'b1;
    else if (|evm_vote) vip <= 1'b0;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; enable = 1'b0; booth_req = '0; booth_choice = '0; close_session = 1'b0; vip_en = 1'b1;
    #3;
    checks++; if (all_out !== 22'd0) $display("FAIL reset_outputs: got %h exp 0", all_out); else passed++;
    checks++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d exp 0", dbg_state); else passed++;
    step; step;
    rst = 1'b1; enable = 1'b1;
    step;
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b exp 0", busy); else passed++;
  endtask

  task automatic test_single_vote;
    booth_req = 4'b0001; booth_choice = 8'b00_00_00_01;
    step;
    checks++; if (evm_candidate_ready !== 1'b1) $display("FAIL sv_cready: got %b exp 1", evm_candidate_ready); else passed++;
    step;
    checks++; if (evm_candidate_ready !== 1'b0) $display("FAIL sv_cready_width: got %b exp 0", evm_candidate_ready); else passed++;
    step;
    checks++; if (evm_vote !== 3'b001) $display("FAIL sv_vote: got %b exp 001", evm_vote); else passed++;
    step;
    checks++; if ({evm_vote, booth_ack} !== 7'd0) $display("FAIL sv_settle: got %b exp 0", {evm_vote, booth_ack}); else passed++;
    step;
    checks++; if (booth_ack !== 4'b0001) $display("FAIL sv_ack: got %b exp 0001", booth_ack); else passed++;
    checks++; if (votes_cast !== 7'd1) $display("FAIL sv_votes: got %0d exp 1", votes_cast); else passed++;
    booth_req = '0;
    step;
    checks++; if ({booth_ack, busy} !== 5'd0) $display("FAIL sv_back_idle: got %b exp 0", {booth_ack, busy}); else passed++;
  endtask

  task automatic test_revote;
    booth_req = 4'b0100; booth_choice = 8'b00_10_00_00;
    step; step; step;
    checks++; if (evm_vote !== 3'b010) $display("FAIL rv_vote: got %b exp 010", evm_vote); else passed++;
    step; step;
    checks++; if (booth_ack !== 4'b0100) $display("FAIL rv_ack: got %b exp 0100", booth_ack); else passed++;
    booth_req = '0;
    step;
    booth_req = 4'b0100;
    step;
    checks++; if (booth_nack !== 4'b0100) $display("FAIL rv_nack: got %b exp 0100", booth_nack); else passed++;
    checks++; if (evm_candidate_ready !== 1'b0) $display("FAIL rv_no_cready: got %b exp 0", evm_candidate_ready); else passed++;
    checks++; if (votes_cast !== 7'd2) $display("FAIL rv_votes: got %0d exp 2", votes_cast); else passed++;
    booth_req = '0;
    step;
  endtask

  task automatic test_invalid;
    booth_req = 4'b0010; booth_choice = 8'b00_00_00_00;
    step;
    checks++; if (booth_nack !== 4'b0010) $display("FAIL inv_nack: got %b exp 0010", booth_nack); else passed++;
    checks++; if (evm_candidate_ready !== 1'b0) $display("FAIL inv_cready: got %b exp 0", evm_candidate_ready); else passed++;
    booth_req = '0;
    step;
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    vip_en = 1'b0;
    booth_req = 4'b1000; booth_choice = 8'b11_00_00_00;
    step;
    checks++; if (evm_candidate_ready !== 1'b1) $display("FAIL to_cready: got %b exp 1", evm_candidate_ready); else passed++;
    for (int c = 0; c < 16; c++) begin
      step;
      if ((|booth_nack) || (|booth_ack) || (|evm_vote)) early++;
    end
    checks++; if (early !== 0) $display("FAIL to_early_resp: got %0d exp 0", early); else passed++;
    step;
    checks++; if (booth_nack !== 4'b1000) $display("FAIL to_nack: got %b exp 1000", booth_nack); else passed++;
    booth_req = '0; vip_en = 1'b1;
    step;
    booth_req = 4'b1000;
    step; step; step;
    checks++; if (evm_vote !== 3'b100) $display("FAIL to_retry_vote: got %b exp 100", evm_vote); else passed++;
    step; step;
    checks++; if (booth_ack !== 4'b1000) $display("FAIL to_retry_ack: got %b exp 1000", booth_ack); else passed++;
    checks++; if (votes_cast !== 7'd3) $display("FAIL to_votes: got %0d exp 3", votes_cast); else passed++;
    booth_req = '0;
    step;
  endtask

  task automatic test_close;
    close_session = 1'b1;
    step;
    checks++; if ({evm_session_done, busy} !== 2'b11) $display("FAIL cl_done: got %b exp 11", {evm_session_done, busy}); else passed++;
    step;
    checks++; if ({evm_session_done, busy, session_closed} !== 3'b001) $display("FAIL cl_closed: got %b exp 001", {evm_session_done, busy, session_closed}); else passed++;
    close_session = 1'b0;
    booth_req = 4'b0010; booth_choice = 8'b00_00_01_00;
    step;
    checks++; if (booth_nack !== 4'b0010) $display("FAIL cl_nack: got %b exp 0010", booth_nack); else passed++;
    step;
    checks++; if ({booth_nack, evm_candidate_ready, session_closed} !== 6'b000001) $display("FAIL cl_nack_once: got %b exp 000001", {booth_nack, evm_candidate_ready, session_closed}); else passed++;
    booth_req = '0;
    step;
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_vote [4];
    logic [2:0] seen_vote;
    logic [NB-1:0] exp_ack;
    int got;
    exp_vote = '{3'b100, 3'b001, 3'b010, 3'b100};
    rst = 1'b0;
    step;
    rst = 1'b1;
    step;
    booth_req = 4'b1111; booth_choice = 8'b11_10_01_11;
    for (int b = 0; b < 4; b++) begin
      got = 0; seen_vote = 3'b000;
      for (int c = 0; c < 12 && got == 0; c++) begin
        step;
        if (|evm_vote) seen_vote = evm_vote;
        if ((|booth_ack) || (|booth_nack)) got = 1;
      end
      exp_ack = 4'b0001 << b;
      checks++; if (booth_ack !== exp_ack) $display("FAIL rr_ack%0d: got %b exp %b", b, booth_ack, exp_ack); else passed++;
      checks++; if (seen_vote !== exp_vote[b]) $display("FAIL rr_vote%0d: got %b exp %b", b, seen_vote, exp_vote[b]); else passed++;
      booth_req[b] = 1'b0;
    end
    got = 0;
    for (int c = 0; c < 4 && got == 0; c++) begin
      step;
      if (evm_session_done) got = 1;
    end
    checks++; if (got !== 1) $display("FAIL rr_session_done: got %0d exp 1", got); else passed++;
    step;
    checks++; if (session_closed !== 1'b1) $display("FAIL rr_closed: got %b exp 1", session_closed); else passed++;
    checks++; if (votes_cast !== 7'd4) $display("FAIL rr_votes: got %0d exp 4", votes_cast); else passed++;
  endtask

  task automatic test_enable_clear;
    enable = 1'b0;
    step;
    enable = 1'b1;
    booth_req = 4'b0001; booth_choice = 8'b00_00_10_01;
    step; step; step; step; step;
    checks++; if ({booth_ack, votes_cast} !== {4'b0001, 7'd1}) $display("FAIL en_first_vote: got %b exp 0001_0000001", {booth_ack, votes_cast}); else passed++;
    booth_req = 4'b0010;
    step;
    step; step; step;
    checks++; if (evm_vote !== 3'b010) $display("FAIL en_vote: got %b exp 010", evm_vote); else passed++;
    enable = 1'b0;
    step;
    checks++; if (dbg_state !== 3'd0) $display("FAIL en_state: got %0d exp 0", dbg_state); else passed++;
    checks++; if (all_out !== 22'd0) $display("FAIL en_outputs: got %h exp 0", all_out); else passed++;
    enable = 1'b1; booth_req = '0;
    step;
  endtask

  task automatic test_async_reset;
    booth_req = 4'b0100; booth_choice = 8'b00_01_00_00;
    step;
    checks++; if (evm_candidate_ready !== 1'b1) $display("FAIL ar_grant: got %b exp 1", evm_candidate_ready); else passed++;
    #2 rst = 1'b0;
    #1;
    checks++; if (all_out !== 22'd0) $display("FAIL ar_outputs: got %h exp 0", all_out); else passed++;
    booth_req = '0;
    step;
    rst = 1'b1;
    step;
  endtask

  initial begin
    test_reset;
    test_single_vote;
    test_revote;
    test_invalid;
    test_timeout;
    test_close;
    test_round_robin;
    test_enable_clear;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
